// File: rtl/bti_arb2_if.sv
// rtl/bti_arb2_if.sv - request channel bundle shared by requesters and the downstream port
interface bti_arb2_if #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int TID_W = 4,
    parameter int CMD_W = 2
);
    typedef struct packed {
        logic [TID_W-1:0]  tid;
        logic [CMD_W-1:0]  cmd;
        logic [AW-1:0]     addr;
        logic [DW-1:0]     data;
        logic [DW/8-1:0]   strobe;
    } pkt_t;

    logic vld;
    logic rdy;
    pkt_t pkt;

    modport mst (output vld, output pkt, input rdy);
    modport slv (input vld, input pkt, output rdy);
endinterface

// File: rtl/bti_arb2.sv
// rtl/bti_arb2.sv - two-requester round-robin arbiter with in-order response routing
module bti_arb2 #(
    parameter int BTI_AW   = 32,
    parameter int BTI_DW   = 32,
    parameter int OT_DEPTH = 4,
    parameter int TID_W    = 4,
    parameter int CMD_W    = 2,
    parameter int RSP_W    = BTI_DW + 2
) (
    input  logic              clk,
    input  logic              rst,
    bti_arb2_if.slv           m0_req,
    bti_arb2_if.slv           m1_req,
    bti_arb2_if.mst           s_req,
    input  logic              s_rsp_vld,
    output logic              s_rsp_rdy,
    input  logic [RSP_W-1:0]  s_rsp_pkt,
    output logic              m0_rsp_vld,
    input  logic              m0_rsp_rdy,
    output logic [RSP_W-1:0]  m0_rsp_pkt,
    output logic              m1_rsp_vld,
    input  logic              m1_rsp_rdy,
    output logic [RSP_W-1:0]  m1_rsp_pkt
);
    localparam int PKT_W = TID_W + CMD_W + BTI_AW + BTI_DW + BTI_DW / 8;
    localparam int PW    = $clog2(OT_DEPTH);
    localparam int CW    = PW + 1;

    typedef enum logic [1:0] {
        ARB_OPEN  = 2'd0,
        ARB_HOLD0 = 2'd1,
        ARB_HOLD1 = 2'd2
    } arb_state_t;

    arb_state_t        arb_state;
    arb_state_t        arb_nxt;
    logic              rr;
    logic              el0;
    logic              el1;
    logic              gnt_vld;
    logic              gnt_id;
    logic              req_hs;
    logic [PKT_W-1:0]  fwd_pkt;

    logic              mem [OT_DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic              full_q;
    logic              empty_q;
    logic              push;
    logic              pop;
    logic              head_id;
    logic              rsp_live;

    // Hold states keep a stalled grant pinned; the lock only forms when
    // s_req is presented without rdy, so full_q cannot rise while held.
    always_comb begin
        arb_nxt = ARB_OPEN;
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        el0     = m0_req.vld & ~full_q;
        el1     = m1_req.vld & ~full_q;
        case (arb_state)
            ARB_HOLD0: begin
                gnt_vld = m0_req.vld;
                gnt_id  = 1'b0;
            end
            ARB_HOLD1: begin
                gnt_vld = m1_req.vld;
                gnt_id  = 1'b1;
            end
            default: begin
                gnt_vld = el0 | el1;
                gnt_id  = (el0 & el1) ? rr : el1;
            end
        endcase
        if (rst) begin
            gnt_vld = 1'b0;
        end
        if (gnt_vld && !s_req.rdy) begin
            arb_nxt = gnt_id ? ARB_HOLD1 : ARB_HOLD0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arb_state <= ARB_OPEN;
        end else begin
            arb_state <= arb_nxt;
        end
    end

    assign fwd_pkt    = gnt_id ? m1_req.pkt : m0_req.pkt;
    assign s_req.pkt  = fwd_pkt;
    assign s_req.vld  = gnt_vld;
    assign m0_req.rdy = gnt_vld & ~gnt_id & s_req.rdy;
    assign m1_req.rdy = gnt_vld &  gnt_id & s_req.rdy;
    assign req_hs     = gnt_vld & s_req.rdy;

    assign push     = req_hs;
    assign head_id  = mem[rptr];
    assign rsp_live = s_rsp_vld & ~empty_q & ~rst;

    assign s_rsp_rdy  = ~empty_q & ~rst & (head_id ? m1_rsp_rdy : m0_rsp_rdy);
    assign pop        = rsp_live & s_rsp_rdy;
    assign m0_rsp_vld = rsp_live & ~head_id;
    assign m1_rsp_vld = rsp_live &  head_id;
    assign m0_rsp_pkt = s_rsp_pkt;
    assign m1_rsp_pkt = s_rsp_pkt;

    always_comb begin
        cnt_nxt = cnt;
        case ({push, pop})
            2'b10:   cnt_nxt = cnt + CW'(1);
            2'b01:   cnt_nxt = cnt - CW'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr      <= 1'b0;
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (req_hs) begin
                rr <= ~gnt_id;
            end
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            cnt     <= cnt_nxt;
            full_q  <= (cnt_nxt == CW'(OT_DEPTH));
            empty_q <= (cnt_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= gnt_id;
        end
    end

    rsp_without_request: assert property (@(posedge clk) disable iff (rst) !(s_rsp_vld && empty_q));

endmodule

// File: tb/tb_bti_arb2.sv
// tb/tb_bti_arb2.sv - scoreboard bench for the two-requester arbiter
module tb_bti_arb2;
    localparam int RSP_W = 34;
    localparam int PKT_W = 74;

    typedef struct {
        logic        id;
        logic [31:0] addr;
    } req_exp_t;

    typedef struct {
        logic             id;
        logic [RSP_W-1:0] pkt;
    } rsp_exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             s_rsp_vld;
    logic             s_rsp_rdy;
    logic [RSP_W-1:0] s_rsp_pkt;
    logic             m0_rsp_vld;
    logic             m0_rsp_rdy;
    logic [RSP_W-1:0] m0_rsp_pkt;
    logic             m1_rsp_vld;
    logic             m1_rsp_rdy;
    logic [RSP_W-1:0] m1_rsp_pkt;

    int total = 0;
    int bad   = 0;
    int out_cnt = 0;
    logic hs0_f = 1'b0;
    logic hs1_f = 1'b0;
    logic rsp_f = 1'b0;

    logic [31:0]      src0 [$];
    logic [31:0]      src1 [$];
    logic [RSP_W-1:0] rsp_q [$];
    req_exp_t         exp_req [$];
    rsp_exp_t         exp_rsp [$];
    req_exp_t         e;
    rsp_exp_t         r;

    always #5 clk = ~clk;

    bti_arb2_if #(.AW(32), .DW(32), .TID_W(4), .CMD_W(2)) m0_if ();
    bti_arb2_if #(.AW(32), .DW(32), .TID_W(4), .CMD_W(2)) m1_if ();
    bti_arb2_if #(.AW(32), .DW(32), .TID_W(4), .CMD_W(2)) s_if ();

    bti_arb2 #(
        .BTI_AW(32), .BTI_DW(32), .OT_DEPTH(4), .TID_W(4), .CMD_W(2), .RSP_W(RSP_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .m0_req(m0_if),
        .m1_req(m1_if),
        .s_req(s_if),
        .s_rsp_vld(s_rsp_vld),
        .s_rsp_rdy(s_rsp_rdy),
        .s_rsp_pkt(s_rsp_pkt),
        .m0_rsp_vld(m0_rsp_vld),
        .m0_rsp_rdy(m0_rsp_rdy),
        .m0_rsp_pkt(m0_rsp_pkt),
        .m1_rsp_vld(m1_rsp_vld),
        .m1_rsp_rdy(m1_rsp_rdy),
        .m1_rsp_pkt(m1_rsp_pkt)
    );

    function automatic logic [PKT_W-1:0] mkpkt(input logic [31:0] a);
        return {a[3:0], 2'b01, a, a ^ 32'hdead_0000, 4'hf};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (s_if.vld && s_if.rdy) begin
                hs0_f = m0_if.rdy;
                hs1_f = m1_if.rdy;
                out_cnt++;
                if (exp_req.size() == 0) begin
                    chk("req_unexpected", 1, 0);
                end else begin
                    e = exp_req.pop_front();
                    chk("req_id", m1_if.rdy, e.id);
                    chk("req_pkt", s_if.pkt, mkpkt(e.addr));
                end
            end
            if (s_rsp_vld && s_rsp_rdy) begin
                rsp_f = 1'b1;
                out_cnt--;
            end
            if (m0_rsp_vld && m1_rsp_vld) chk("rsp_both_vld", 1, 0);
            if ((m0_rsp_vld && m0_rsp_rdy) || (m1_rsp_vld && m1_rsp_rdy)) begin
                if (exp_rsp.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    r = exp_rsp.pop_front();
                    chk("rsp_id", m1_rsp_vld, r.id);
                    chk("rsp_pkt", m1_rsp_vld ? m1_rsp_pkt : m0_rsp_pkt, r.pkt);
                end
            end
        end
    end

    task automatic drive();
        if (hs0_f && src0.size() > 0) src0.delete(0);
        if (hs1_f && src1.size() > 0) src1.delete(0);
        if (rsp_f && rsp_q.size() > 0) rsp_q.delete(0);
        hs0_f = 1'b0;
        hs1_f = 1'b0;
        rsp_f = 1'b0;
        m0_if.vld = (src0.size() > 0);
        m0_if.pkt = (src0.size() > 0) ? mkpkt(src0[0]) : '0;
        m1_if.vld = (src1.size() > 0);
        m1_if.pkt = (src1.size() > 0) ? mkpkt(src1[0]) : '0;
        s_rsp_vld = (rsp_q.size() > 0) && (out_cnt > 0);
        s_rsp_pkt = (rsp_q.size() > 0) ? rsp_q[0] : '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic exp_q(input logic id, input logic [31:0] a);
        req_exp_t x;
        x.id = id;
        x.addr = a;
        exp_req.push_back(x);
    endtask

    task automatic rsp_give(input logic id, input logic [RSP_W-1:0] p);
        rsp_exp_t x;
        x.id = id;
        x.pkt = p;
        exp_rsp.push_back(x);
        rsp_q.push_back(p);
    endtask

    task automatic wait_req_idle(input string nm);
        int n = 0;
        while ((src0.size() > 0 || src1.size() > 0 || exp_req.size() > 0) && n < 60) begin
            tick();
            n++;
        end
        chk({nm, "_req_timeout"}, n < 60, 1);
    endtask

    task automatic wait_rsp_idle(input string nm);
        int n = 0;
        while ((rsp_q.size() > 0 || exp_rsp.size() > 0) && n < 60) begin
            tick();
            n++;
        end
        chk({nm, "_rsp_timeout"}, n < 60, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        s_if.rdy = 1'b1;
        m0_rsp_rdy = 1'b1;
        m1_rsp_rdy = 1'b1;
        src0.push_back(32'h44);
        src1.push_back(32'h48);
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_vld", s_if.vld, 0);
        chk("rst_m0_rdy", m0_if.rdy, 0);
        chk("rst_m1_rdy", m1_if.rdy, 0);
        chk("rst_m0_rsp_vld", m0_rsp_vld, 0);
        chk("rst_m1_rsp_vld", m1_rsp_vld, 0);
        chk("rst_s_rsp_rdy", s_rsp_rdy, 0);
        src0.delete();
        src1.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_s_vld", s_if.vld, 0);
        chk("idle_s_rsp_rdy", s_rsp_rdy, 0);

        // alternating grants, one handshake per cycle, m0 first
        src0 = '{32'h10, 32'h14, 32'h18};
        src1 = '{32'h20, 32'h24, 32'h28};
        exp_q(0, 32'h10); exp_q(1, 32'h20); exp_q(0, 32'h14);
        exp_q(1, 32'h24); exp_q(0, 32'h18); exp_q(1, 32'h28);
        for (int i = 0; i < 6; i++) rsp_give(i[0], RSP_W'(34'h100 + i));
        tick();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t1_hs_each_cycle", s_if.vld & s_if.rdy, 1);
            tick();
        end
        wait_req_idle("t1");
        wait_rsp_idle("t1");

        // stalled m1 grant is not preempted by m0
        s_if.rdy = 1'b0;
        src1.push_back(32'h100);
        exp_q(1, 32'h100);
        exp_q(0, 32'h200);
        tick();
        @(negedge clk);
        chk("t2_c1_vld", s_if.vld, 1);
        chk("t2_c1_pkt", s_if.pkt, mkpkt(32'h100));
        src0.push_back(32'h200);
        tick();
        @(negedge clk);
        chk("t2_c2_pkt", s_if.pkt, mkpkt(32'h100));
        tick();
        @(negedge clk);
        chk("t2_c3_pkt", s_if.pkt, mkpkt(32'h100));
        tick();
        s_if.rdy = 1'b1;
        @(negedge clk);
        chk("t2_c4_pkt", s_if.pkt, mkpkt(32'h100));
        chk("t2_c4_m1_rdy", m1_if.rdy, 1);
        tick();
        @(negedge clk);
        chk("t2_c5_pkt", s_if.pkt, mkpkt(32'h200));
        chk("t2_c5_m0_rdy", m0_if.rdy, 1);
        rsp_give(1, 34'h2_0000_0001);
        rsp_give(0, 34'h2_0000_0002);
        wait_req_idle("t2");
        wait_rsp_idle("t2");

        // fill the routing FIFO, then free one slot
        src0 = '{32'h30, 32'h34, 32'h38};
        src1 = '{32'h40, 32'h44, 32'h48};
        exp_q(1, 32'h40); exp_q(0, 32'h30); exp_q(1, 32'h44);
        exp_q(0, 32'h34); exp_q(1, 32'h48); exp_q(0, 32'h38);
        repeat (5) tick();
        @(negedge clk);
        chk("t3_full_s_vld", s_if.vld, 0);
        chk("t3_full_m0_rdy", m0_if.rdy, 0);
        chk("t3_full_m1_rdy", m1_if.rdy, 0);
        chk("t3_full_cnt", dut.cnt, 4);
        rsp_give(1, 34'h3_0000_0000);
        tick();
        @(negedge clk);
        chk("t3_pop_cycle_s_vld", s_if.vld, 0);
        chk("t3_pop_cycle_rsp_rdy", s_rsp_rdy, 1);
        tick();
        @(negedge clk);
        chk("t3_resume_vld", s_if.vld, 1);
        chk("t3_resume_pkt", s_if.pkt, mkpkt(32'h48));
        tick();
        @(negedge clk);
        chk("t3_refull_vld", s_if.vld, 0);
        rsp_give(0, 34'h3_0000_0001);
        rsp_give(1, 34'h3_0000_0002);
        rsp_give(0, 34'h3_0000_0003);
        rsp_give(1, 34'h3_0000_0004);
        rsp_give(0, 34'h3_0000_0005);
        wait_req_idle("t3");
        wait_rsp_idle("t3");

        // m0,m1,m0 then responses with m1 back-pressure
        src0.push_back(32'h50); exp_q(0, 32'h50); wait_req_idle("t4a");
        src1.push_back(32'h54); exp_q(1, 32'h54); wait_req_idle("t4b");
        src0.push_back(32'h58); exp_q(0, 32'h58); wait_req_idle("t4c");
        m1_rsp_rdy = 1'b0;
        rsp_give(0, 34'h0_4000_0000);
        rsp_give(1, 34'h0_4000_0001);
        rsp_give(0, 34'h0_4000_0002);
        tick();
        @(negedge clk);
        chk("t4_a_m0_vld", m0_rsp_vld, 1);
        tick();
        @(negedge clk);
        chk("t4_b_m1_vld", m1_rsp_vld, 1);
        chk("t4_b_s_rsp_rdy", s_rsp_rdy, 0);
        tick();
        @(negedge clk);
        chk("t4_c_s_rsp_rdy", s_rsp_rdy, 0);
        chk("t4_c_m0_vld", m0_rsp_vld, 0);
        tick();
        m1_rsp_rdy = 1'b1;
        @(negedge clk);
        chk("t4_d_s_rsp_rdy", s_rsp_rdy, 1);
        wait_rsp_idle("t4");

        // push and pop in the same cycle at count 2
        src0.push_back(32'h60);
        src1.push_back(32'h64);
        exp_q(1, 32'h64);
        exp_q(0, 32'h60);
        wait_req_idle("t5a");
        chk("t5_cnt_before", dut.cnt, 2);
        src0.push_back(32'h68);
        exp_q(0, 32'h68);
        rsp_give(1, 34'h0_5000_0000);
        tick();
        @(negedge clk);
        chk("t5_push_hs", s_if.vld & s_if.rdy, 1);
        chk("t5_pop_hs", s_rsp_vld & s_rsp_rdy, 1);
        tick();
        @(negedge clk);
        chk("t5_cnt_after", dut.cnt, 2);
        rsp_give(0, 34'h0_5000_0001);
        rsp_give(0, 34'h0_5000_0002);
        wait_rsp_idle("t5");
        chk("t5_wptr_wrap", dut.wptr, 0);
        chk("t5_rptr_wrap", dut.rptr, 0);

        // reset with three requests outstanding
        src0 = '{32'h70, 32'h74, 32'h78};
        exp_q(0, 32'h70); exp_q(0, 32'h74); exp_q(0, 32'h78);
        wait_req_idle("t6a");
        chk("t6_cnt_pre", dut.cnt, 3);
        chk("t6_rr_pre", dut.rr, 1);
        src0.push_back(32'h84);
        src1.push_back(32'h80);
        rst = 1'b1;
        drive();
        @(negedge clk);
        chk("t6_rst_s_vld", s_if.vld, 0);
        chk("t6_rst_m0_rdy", m0_if.rdy, 0);
        chk("t6_rst_m1_rdy", m1_if.rdy, 0);
        tick();
        @(negedge clk);
        chk("t6_cnt", dut.cnt, 0);
        chk("t6_rr", dut.rr, 0);
        chk("t6_s_rsp_rdy", s_rsp_rdy, 0);
        chk("t6_rsp_vld", m0_rsp_vld | m1_rsp_vld, 0);
        out_cnt = 0;
        tick();
        rst = 1'b0;
        exp_q(0, 32'h84);
        exp_q(1, 32'h80);
        wait_req_idle("t6b");
        rsp_give(0, 34'h0_6000_0000);
        rsp_give(1, 34'h0_6000_0001);
        wait_rsp_idle("t6");

        chk("end_req_left", exp_req.size(), 0);
        chk("end_rsp_left", exp_rsp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
